// File: rtl/image_loader_pkg.sv
// Shared sizes, sync marker and FSM state encoding for the image frame loader.
package image_loader_pkg;

  localparam int unsigned IMG_BITS  = 784;
  localparam int unsigned IMG_BYTES = 98;
  localparam int unsigned SLOT_BITS = 4;
  localparam int unsigned IDX_W     = 7;
  localparam int unsigned BIT_IDX_W = IDX_W + 3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_SLOT   = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_CHECK  = 3'd3;
  localparam logic [2:0] ENC_COMMIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_SLOT   = ENC_SLOT,
    ST_DATA   = ENC_DATA,
    ST_CHECK  = ENC_CHECK,
    ST_COMMIT = ENC_COMMIT
  } state_t;

endpackage

// File: rtl/image_frame_loader_timer.sv
// Inter-byte watchdog: counts while running, pulses o_expired for the cycle
// in which the count sits at TIMEOUT_CYCLES-1.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PRE_EXPIRE = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] r_count;
  logic             r_expired;

  // Expiry is registered one count early so it lines up with count == TIMEOUT_CYCLES-1.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= i_run && !i_clear && (r_count == PRE_EXPIRE);
      if (i_clear) begin
        r_count <= '0;
      end else if (i_run) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/image_frame_loader.sv
// Assembles UART byte frames (sync, slot, 98 data bytes, XOR checksum) into
// 784-bit images and writes checked frames into the image RAM.
module image_frame_loader
  import image_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic                 o_wr_en,
  output logic [SLOT_BITS-1:0] o_wr_addr,
  output logic [IMG_BITS-1:0]  o_wr_data,
  output logic                 o_busy,
  output logic                 o_err_chk,
  output logic                 o_err_frame,
  output logic                 o_err_timeout,
  output logic [7:0]           o_frame_count
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SLOT_BITS-1:0]  r_slot;
  logic [SLOT_BITS-1:0]  r_wr_addr;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_xor;
  logic [IMG_BITS-1:0]   r_buf;
  logic                  r_wr_en;
  logic                  r_busy;
  logic                  r_err_chk;
  logic                  r_err_frame;
  logic                  r_err_timeout;
  logic [7:0]            r_frame_count;

  logic                  w_err_chk_nxt;
  logic                  w_err_frame_nxt;
  logic                  w_err_timeout_nxt;
  logic                  w_expired;
  logic                  w_tmr_clear;
  logic                  w_tmr_run;
  logic                  w_slot_ok;
  logic                  w_last_byte;
  logic [BIT_IDX_W-1:0]  w_bit_base;

  assign w_slot_ok   = (i_rx_data[7:SLOT_BITS] == '0);
  assign w_last_byte = (r_idx == IDX_W'(IMG_BYTES - 1));
  assign w_bit_base  = {r_idx, 3'b000};
  assign w_tmr_clear = i_rx_valid || (r_state == ST_IDLE);
  assign w_tmr_run   = (r_state == ST_SLOT) || (r_state == ST_DATA) || (r_state == ST_CHECK);

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_clear  (w_tmr_clear),
    .i_run    (w_tmr_run),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and error pulses; an arriving byte always takes priority over expiry.
  always_comb begin
    w_state_nxt       = r_state;
    w_err_chk_nxt     = 1'b0;
    w_err_frame_nxt   = 1'b0;
    w_err_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
          w_state_nxt = ST_SLOT;
        end
      end
      ST_SLOT: begin
        if (i_rx_valid) begin
          if (w_slot_ok) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt     = ST_IDLE;
            w_err_frame_nxt = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt       = ST_IDLE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_rx_valid) begin
          if (w_last_byte) begin
            w_state_nxt = ST_CHECK;
          end
        end else if (w_expired) begin
          w_state_nxt       = ST_IDLE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        if (i_rx_valid) begin
          if (i_rx_data == r_xor) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_err_chk_nxt = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt       = ST_IDLE;
          w_err_timeout_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_slot        <= '0;
      r_wr_addr     <= '0;
      r_idx         <= '0;
      r_xor         <= '0;
      r_buf         <= '0;
      r_wr_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_wr_en       <= (w_state_nxt == ST_COMMIT);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_err_chk     <= w_err_chk_nxt;
      r_err_frame   <= w_err_frame_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      if (w_state_nxt == ST_COMMIT) begin
        r_wr_addr <= r_slot;
      end
      if (r_state == ST_COMMIT) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
      if ((r_state == ST_SLOT) && i_rx_valid && w_slot_ok) begin
        r_slot <= i_rx_data[SLOT_BITS-1:0];
        r_xor  <= i_rx_data;
        r_idx  <= '0;
      end
      if ((r_state == ST_DATA) && i_rx_valid) begin
        r_buf[w_bit_base +: 8] <= i_rx_data;
        r_xor                  <= r_xor ^ i_rx_data;
        r_idx                  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_buf;
  assign o_busy        = r_busy;
  assign o_err_chk     = r_err_chk;
  assign o_err_frame   = r_err_frame;
  assign o_err_timeout = r_err_timeout;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_image_frame_loader.sv
// Scoreboard bench for image_frame_loader: frame-level reference model pushes
// expected RAM writes / error pulses, a negedge monitor pops and compares.
module tb_image_frame_loader;

  localparam int unsigned TO = 100;
  localparam int EV_WR  = 0;
  localparam int EV_CHK = 1;
  localparam int EV_FRM = 2;
  localparam int EV_TO  = 3;

  typedef struct {
    int           kind;
    logic [3:0]   addr;
    logic [783:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_rx_valid;
  logic [7:0]   i_rx_data;
  logic         o_wr_en;
  logic [3:0]   o_wr_addr;
  logic [783:0] o_wr_data;
  logic         o_busy;
  logic         o_err_chk;
  logic         o_err_frame;
  logic         o_err_timeout;
  logic [7:0]   o_frame_count;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] fdata [98];
  logic [7:0] model_count;
  logic [3:0] model_addr;
  int         found;

  always #5 clk = ~clk;

  image_frame_loader #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_err_chk    (o_err_chk),
    .o_err_frame  (o_err_frame),
    .o_err_timeout(o_err_timeout),
    .o_frame_count(o_frame_count)
  );

  task automatic check(input string name, input logic [783:0] got, input logic [783:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic pop_event(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event got kind %0d required none", kind);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      n_fail++;
      $display("FAIL event_kind got %0d required %0d", kind, e.kind);
    end else if (kind == EV_WR) begin
      check("wr_addr", 784'(o_wr_addr), 784'(e.addr));
      check("wr_data", o_wr_data, e.data);
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_wr_en)       pop_event(EV_WR);
      if (o_err_chk)     pop_event(EV_CHK);
      if (o_err_frame)   pop_event(EV_FRM);
      if (o_err_timeout) pop_event(EV_TO);
    end
  end

  task automatic drive(input logic [7:0] b, input int gap);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 98; k++) fdata[k] = 8'($urandom);
  endtask

  // Reference model at frame level: expected image from bit mapping, checksum by XOR reduction.
  task automatic send_frame(input logic [7:0] slot_b, input bit corrupt, input int max_gap,
                            input int long_idx, input int long_gap, input int last_gap);
    logic [7:0]   x;
    logic [783:0] img;
    x   = slot_b;
    img = '0;
    for (int k = 0; k < 98; k++) begin
      x = x ^ fdata[k];
      for (int j = 0; j < 8; j++) img[8*k + j] = fdata[k][j];
    end
    if (corrupt) begin
      x = ~x;
      exp_q.push_back('{EV_CHK, 4'h0, '0});
    end else begin
      exp_q.push_back('{EV_WR, slot_b[3:0], img});
      model_count = model_count + 8'd1;
      model_addr  = slot_b[3:0];
    end
    drive(8'hA5, $urandom_range(0, max_gap));
    drive(slot_b, $urandom_range(0, max_gap));
    for (int k = 0; k < 98; k++)
      drive(fdata[k], (k == long_idx) ? long_gap : int'($urandom_range(0, max_gap)));
    drive(x, last_gap);
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_busy"},  784'(o_busy), 784'(0));
    check({tag, "_count"}, 784'(o_frame_count), 784'(model_count));
    check({tag, "_addr"},  784'(o_wr_addr), 784'(model_addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset     = 1'b1;
    i_rx_valid  = 1'b0;
    i_rx_data   = 8'h00;
    model_count = 8'd0;
    model_addr  = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",    784'(o_busy), 784'(0));
    check("rst_wr_en",   784'(o_wr_en), 784'(0));
    check("rst_wr_addr", 784'(o_wr_addr), 784'(0));
    check("rst_wr_data", o_wr_data, 784'(0));
    check("rst_errs",    784'({o_err_chk, o_err_frame, o_err_timeout}), 784'(0));
    check("rst_count",   784'(o_frame_count), 784'(0));
    i_reset = 1'b0;

    // Reset after 40 data bytes; the tail of that frame must be ignored.
    fill_random();
    drive(8'hA5, 0);
    drive(8'h07, 1);
    for (int k = 0; k < 40; k++) drive(fdata[k], $urandom_range(0, 2));
    check("pre_rst_busy", 784'(o_busy), 784'(1));
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    model_count = 8'd0;
    model_addr  = 4'd0;
    check("midrst_busy",    784'(o_busy), 784'(0));
    check("midrst_wr_data", o_wr_data, 784'(0));
    check("midrst_count",   784'(o_frame_count), 784'(0));
    for (int k = 40; k < 98; k++) drive(fdata[k] & 8'h7F, 0);
    drive(8'h3C, 0);
    settle("post_rst");

    // Counting-pattern frame to slot 3.
    for (int k = 0; k < 98; k++) fdata[k] = 8'(k);
    send_frame(8'h03, 1'b0, 0, -1, 0, 2);
    settle("t1");

    // Inverted checksum, then a good frame to slot 5.
    send_frame(8'h03, 1'b1, 1, -1, 0, 1);
    settle("t2_bad");
    fill_random();
    send_frame(8'h05, 1'b0, 1, -1, 0, 1);
    settle("t2_good");

    // Illegal slot byte, then 98 bytes of 0xFF.
    exp_q.push_back('{EV_FRM, 4'h0, '0});
    drive(8'hA5, 0);
    drive(8'h12, 1);
    check("t3_busy", 784'(o_busy), 784'(0));
    for (int k = 0; k < 98; k++) drive(8'hFF, 0);
    settle("t3");

    // Silence after 50 data bytes: timeout on cycle TO after the last byte.
    exp_q.push_back('{EV_TO, 4'h0, '0});
    drive(8'hA5, 0);
    drive(8'h00, 0);
    for (int k = 0; k < 50; k++) drive(8'($urandom), (k == 49) ? 0 : int'($urandom_range(0, 2)));
    found = 0;
    for (int i = 1; i <= 2 * TO && found == 0; i++) begin
      @(negedge clk);
      if (o_err_timeout) found = i;
    end
    check("t4_timeout_cycle", 784'(found), 784'(TO));
    check("t4_busy", 784'(o_busy), 784'(0));
    fill_random();
    send_frame(8'h0E, 1'b0, 2, -1, 0, 1);
    settle("t4_after");

    // A byte landing in the expiry cycle wins.
    fill_random();
    send_frame(8'h08, 1'b0, 1, 20, TO - 1, 1);
    settle("boundary_gap");

    // Junk bytes in IDLE.
    drive(8'h00, 1);
    check("t5_busy_00", 784'(o_busy), 784'(0));
    drive(8'h5A, 1);
    check("t5_busy_5a", 784'(o_busy), 784'(0));
    drive(8'hFF, 1);
    check("t5_busy_ff", 784'(o_busy), 784'(0));

    // Sync in the COMMIT cycle starts the next frame.
    fill_random();
    send_frame(8'h09, 1'b0, 1, -1, 0, 0);
    fill_random();
    send_frame(8'h0A, 1'b0, 0, -1, 0, 1);
    settle("t5_b2b");

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      fill_random();
      send_frame(8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 2, -1, 0,
                 $urandom_range(0, 2));
    end
    settle("random");

    repeat (5) @(negedge clk);
    check("exp_queue_empty", 784'(exp_q.size()), 784'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
